// File: rtl/bamse_int_ctrl_pkg.sv
// Shared constants for the bamse interrupt controller: register addresses
// (also consumed by the input mux) and the controller state type.
package bamse_int_ctrl_pkg;

   localparam logic [7:0] INT_MASK = 8'h10;
   localparam logic [7:0] INT_PEND = 8'h11;
   localparam logic [7:0] INT_VEC  = 8'h12;
   localparam logic [7:0] INT_EOI  = 8'h13;

   typedef enum logic [1:0] {
      INT_IDLE    = 2'd0,
      INT_REQ     = 2'd1,
      INT_SERVICE = 2'd2
   } int_state_e;

endpackage

// File: rtl/bamse_int_ctrl_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest asserted request
// plus a valid flag.
module int_prio_enc #(
   parameter int unsigned N_SRC = 4
) (
   input  logic [N_SRC-1:0] req,
   output logic [2:0]       idx,
   output logic             valid
);

   // scan upward, first hit wins
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (req[i] && !valid) begin
            idx   = i[2:0];
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bamse_int_ctrl.sv
// bamse interrupt controller: latches source events into a pending
// register, masks them, and presents the lowest eligible source to the
// PacoBlaze interrupt input with an ack / end-of-interrupt handshake.
module bamse_int_ctrl
   import bamse_int_ctrl_pkg::*;
#(
   parameter int unsigned N_SRC     = 4,
   parameter bit          EDGE      = 1'b1,
   parameter logic [7:0]  ADDR_MASK = INT_MASK,
   parameter logic [7:0]  ADDR_PEND = INT_PEND,
   parameter logic [7:0]  ADDR_VEC  = INT_VEC,
   parameter logic [7:0]  ADDR_EOI  = INT_EOI
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       port_id,
   input  logic [7:0]       port_in,
   input  logic             wen,
   input  logic             ren,
   output logic [7:0]       port_out,
   input  logic [N_SRC-1:0] irq_src,
   output logic             interrupt,
   input  logic             interrupt_ack
);

   logic [N_SRC-1:0] src_q;
   logic [N_SRC-1:0] pend_q, pend_d;
   logic [N_SRC-1:0] mask_q;
   logic [N_SRC-1:0] set_v, clr_v, elig, vec_onehot;
   logic [2:0]       vec_q;
   logic [2:0]       enc_idx;
   logic             enc_valid;
   logic             irq_q;
   int_state_e       state_q;

   logic wr_mask, wr_pend, wr_eoi, ack_take, vec_elig;
   logic unused_bus;

   // reads have no side effects; upper data bits may be unused
   assign unused_bus = ren ^ (^port_in);

   assign wr_mask    = wen && (port_id == ADDR_MASK);
   assign wr_pend    = wen && (port_id == ADDR_PEND);
   assign wr_eoi     = wen && (port_id == ADDR_EOI);
   assign elig       = pend_q & mask_q;
   assign vec_onehot = N_SRC'(1) << vec_q;
   assign vec_elig   = |(elig & vec_onehot);
   assign ack_take   = (state_q == INT_REQ) && interrupt_ack;
   assign interrupt  = irq_q;

   int_prio_enc #(.N_SRC(N_SRC)) u_prio (
      .req   (elig),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   // pending next state: new events win over W1C and ack clears
   always_comb begin
      set_v = EDGE ? (irq_src & ~src_q) : irq_src;
      clr_v = wr_pend ? port_in[N_SRC-1:0] : '0;
      if (ack_take) clr_v = clr_v | vec_onehot;
      pend_d = (pend_q & ~clr_v) | set_v;
   end

   // source history, pending and mask registers
   always_ff @(posedge clk) begin
      if (rst) begin
         src_q  <= '0;
         pend_q <= '0;
         mask_q <= '0;
      end else begin
         src_q  <= irq_src;
         pend_q <= pend_d;
         if (wr_mask) mask_q <= port_in[N_SRC-1:0];
      end
   end

   // request / service handshake with registered interrupt output
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INT_IDLE;
         vec_q   <= '0;
         irq_q   <= 1'b0;
      end else begin
         case (state_q)
            INT_IDLE: begin
               if (enc_valid) begin
                  vec_q   <= enc_idx;
                  irq_q   <= 1'b1;
                  state_q <= INT_REQ;
               end
            end
            INT_REQ: begin
               if (interrupt_ack) begin
                  irq_q   <= 1'b0;
                  state_q <= INT_SERVICE;
               end else if (!vec_elig) begin
                  irq_q   <= 1'b0;
                  state_q <= INT_IDLE;
               end
            end
            INT_SERVICE: begin
               irq_q <= 1'b0;
               if (wr_eoi) state_q <= INT_IDLE;
            end
            default: begin
               irq_q   <= 1'b0;
               state_q <= INT_IDLE;
            end
         endcase
      end
   end

   // register read mux, decoded from port_id alone
   always_comb begin
      if (port_id == ADDR_MASK)
         port_out = 8'(mask_q);
      else if (port_id == ADDR_PEND)
         port_out = 8'(pend_q);
      else if (port_id == ADDR_VEC)
         port_out = {state_q == INT_SERVICE, 4'b0000, vec_q};
      else
         port_out = 8'h00;
   end

endmodule

// File: tb/tb_bamse_int_ctrl.sv
// Self-checking bench for bamse_int_ctrl: directed scenarios followed by
// randomized bus/source traffic, all checked against a behavioural model.
module tb_bamse_int_ctrl;

   localparam logic [7:0] A_MASK = 8'h10;
   localparam logic [7:0] A_PEND = 8'h11;
   localparam logic [7:0] A_VEC  = 8'h12;
   localparam logic [7:0] A_EOI  = 8'h13;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] port_id = 8'h00;
   logic [7:0] port_in = 8'h00;
   logic       wen = 1'b0;
   logic       ren = 1'b0;
   logic [7:0] port_out;
   logic [3:0] irq_src = 4'h0;
   logic       interrupt;
   logic       interrupt_ack = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   // model state: pending/mask sets, request and in-service flags
   int m_prev = 0;
   int m_pend = 0;
   int m_mask = 0;
   int m_vec  = 0;
   bit m_req  = 1'b0;
   bit m_serv = 1'b0;

   bamse_int_ctrl #(
      .N_SRC     (4),
      .EDGE      (1'b1),
      .ADDR_MASK (A_MASK),
      .ADDR_PEND (A_PEND),
      .ADDR_VEC  (A_VEC),
      .ADDR_EOI  (A_EOI)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .port_id       (port_id),
      .port_in       (port_in),
      .wen           (wen),
      .ren           (ren),
      .port_out      (port_out),
      .irq_src       (irq_src),
      .interrupt     (interrupt),
      .interrupt_ack (interrupt_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lowest(input int v);
      for (int i = 0; i < 4; i++)
         if (v % (1 << (i + 1)) >= (1 << i)) return i;
      return 0;
   endfunction

   function automatic logic [7:0] model_read(input logic [7:0] id);
      if (id == A_MASK) return 8'(m_mask);
      if (id == A_PEND) return 8'(m_pend);
      if (id == A_VEC)  return 8'(m_serv * 128 + m_vec);
      return 8'h00;
   endfunction

   // advance the model by one clock using the inputs present at the edge
   task automatic model_step();
      int irq, din, set, clr, elig;
      irq  = int'(irq_src);
      din  = int'(port_in) % 16;
      if (rst) begin
         m_prev = 0; m_pend = 0; m_mask = 0; m_vec = 0;
         m_req = 1'b0; m_serv = 1'b0;
         return;
      end
      set  = irq & ~m_prev & 15;
      clr  = (wen && port_id == A_PEND) ? din : 0;
      elig = m_pend & m_mask;
      if (m_req) begin
         if (interrupt_ack) begin
            clr   = clr | (1 << m_vec);
            m_req  = 1'b0;
            m_serv = 1'b1;
         end else if (((elig >> m_vec) % 2) == 0) begin
            m_req = 1'b0;
         end
      end else if (m_serv) begin
         if (wen && port_id == A_EOI) m_serv = 1'b0;
      end else if (elig != 0) begin
         m_vec = lowest(elig);
         m_req = 1'b1;
      end
      m_pend = (m_pend & ~clr & 15) | set;
      if (wen && port_id == A_MASK) m_mask = din;
      m_prev = irq;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      chk("interrupt", {7'b0, interrupt}, {7'b0, m_req});
      chk("port_out", port_out, model_read(port_id));
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data);
      port_id = addr; port_in = data; wen = 1'b1;
      cycle();
      wen = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
      port_id = addr;
      #1;
      chk(tag, port_out, exp);
   endtask

   task automatic ack();
      interrupt_ack = 1'b1;
      cycle();
      interrupt_ack = 1'b0;
   endtask

   initial begin
      // reset and empty register map
      rst = 1'b1; cycle(); cycle(); rst = 1'b0;
      rd("rst_mask", A_MASK, 8'h00);
      rd("rst_pend", A_PEND, 8'h00);
      rd("rst_vec",  A_VEC,  8'h00);
      chk("rst_int", {7'b0, interrupt}, 8'h00);

      // basic single-source flow
      wr(A_MASK, 8'h0F);
      irq_src = 4'b0100; cycle(); irq_src = 4'h0;
      rd("basic_pend", A_PEND, 8'h04);
      chk("basic_int_t1", {7'b0, interrupt}, 8'h00);
      cycle();
      chk("basic_int_t2", {7'b0, interrupt}, 8'h01);
      ack();
      chk("basic_ack_int", {7'b0, interrupt}, 8'h00);
      rd("basic_ack_pend", A_PEND, 8'h00);
      rd("basic_ack_vec", A_VEC, 8'h82);
      wr(A_EOI, 8'hFF);
      rd("basic_eoi_vec", A_VEC, 8'h02);

      // priority between simultaneous sources
      irq_src = 4'b1010; cycle(); irq_src = 4'h0; cycle();
      chk("prio_int", {7'b0, interrupt}, 8'h01);
      rd("prio_vec1", A_VEC, 8'h01);
      ack();
      rd("prio_pend", A_PEND, 8'h08);
      wr(A_EOI, 8'h00);
      cycle();
      chk("prio_int2", {7'b0, interrupt}, 8'h01);
      rd("prio_vec3", A_VEC, 8'h03);
      ack();
      wr(A_EOI, 8'h00);

      // masked latch, unmask to request, W1C to withdraw
      wr(A_MASK, 8'h00);
      irq_src = 4'b0001; cycle(); irq_src = 4'h0; cycle(); cycle();
      chk("mask_int", {7'b0, interrupt}, 8'h00);
      rd("mask_pend", A_PEND, 8'h01);
      wr(A_MASK, 8'hF1);
      cycle();
      chk("unmask_int", {7'b0, interrupt}, 8'h01);
      wr(A_PEND, 8'h01);
      cycle();
      chk("withdraw_int", {7'b0, interrupt}, 8'h00);
      rd("withdraw_vec", A_VEC, 8'h00);

      // set wins over W1C in the same cycle
      irq_src = 4'b0010; wr(A_PEND, 8'h02); irq_src = 4'h0;
      rd("collide_pend", A_PEND, 8'h02);

      // reset while in service with pending sources
      wr(A_MASK, 8'h0F);
      cycle(); cycle();
      ack();
      irq_src = 4'b1010; cycle(); irq_src = 4'h0; cycle();
      rd("svc_pend", A_PEND, 8'h0A);
      rst = 1'b1; cycle(); rst = 1'b0;
      rd("midrst_mask", A_MASK, 8'h00);
      rd("midrst_pend", A_PEND, 8'h00);
      rd("midrst_vec",  A_VEC,  8'h00);
      chk("midrst_int", {7'b0, interrupt}, 8'h00);
      wr(A_MASK, 8'h0F);
      irq_src = 4'b0100; cycle(); irq_src = 4'h0; cycle();
      chk("postrst_int", {7'b0, interrupt}, 8'h01);
      rd("postrst_vec", A_VEC, 8'h02);

      // randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         rst = ($urandom_range(0, 299) == 0);
         wen = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 5))
            0: port_id = A_MASK;
            1: port_id = A_PEND;
            2: port_id = A_VEC;
            3: port_id = A_EOI;
            4: port_id = 8'h14;
            default: port_id = 8'h00;
         endcase
         port_in = 8'($urandom);
         irq_src = 4'($urandom) & 4'($urandom);
         interrupt_ack = ($urandom_range(0, 2) == 0);
         ren = 1'($urandom);
         cycle();
      end
      rst = 1'b0; wen = 1'b0; interrupt_ack = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
